// File: rtl/seg_capture_if.sv
// rtl/seg_capture_if.sv - capture bus: multiplexed display inputs and decoded frame outputs
interface seg_capture_if;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic [15:0] data_out;
    logic        frame_valid;
    logic        err;
    logic [7:0]  err_cnt;
    logic [3:0]  dp_out;

    modport master (
        output dig, seg,
        input  data_out, frame_valid, err, err_cnt, dp_out
    );

    modport slave (
        input  dig, seg,
        output data_out, frame_valid, err, err_cnt, dp_out
    );
endinterface

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - 7-segment display sniffer: debounced digit capture into BCD frames
// Optional feature: define SEG_CAPTURE_DP_EN to capture per-digit decimal points on dp_out.
module seg_capture #(
    parameter int unsigned STABLE_CNT = 16,
    parameter logic [3:0]  DIG_MASK   = 4'b0011
) (
    input  logic          clk,
    input  logic          rst,
    seg_capture_if.slave  bus
);

`ifdef SEG_CAPTURE_DP_EN
    localparam int SEG_LO = 0;
`else
    localparam int SEG_LO = 1;
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [3:0]      dig_s1, dig_s2, dig_prev;
    logic [7:SEG_LO] seg_s1, seg_s2, seg_prev;
    logic [7:0]      cnt;
    logic [3:0]      captured;
    logic [15:0]     shadow;
    logic [15:0]     data_q;
    logic            frame_valid_q;
    logic            err_q;
    logic [7:0]      err_cnt_q;

    logic [2:0]      zeros;
    logic [1:0]      idx;
    logic            one_hot, multi, changed, in_mask, frame_done;
    logic [4:0]      dec;
    logic            accept, wr, err_event, cnt_restart, cnt_inc;

    function automatic logic [4:0] decode7(input logic [6:0] pat);
        case (pat)
            7'h01:   return {1'b1, 4'd0};
            7'h4F:   return {1'b1, 4'd1};
            7'h12:   return {1'b1, 4'd2};
            7'h06:   return {1'b1, 4'd3};
            7'h4C:   return {1'b1, 4'd4};
            7'h24:   return {1'b1, 4'd5};
            7'h20:   return {1'b1, 4'd6};
            7'h0F:   return {1'b1, 4'd7};
            7'h00:   return {1'b1, 4'd8};
            7'h04:   return {1'b1, 4'd9};
            default: return 5'b0_0000;
        endcase
    endfunction

    // The extra prev stage lets a change be seen on the first synchronized sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_s1   <= '1;
            dig_s2   <= '1;
            dig_prev <= '1;
            seg_s1   <= '1;
            seg_s2   <= '1;
            seg_prev <= '1;
        end else begin
            dig_s1   <= bus.dig;
            dig_s2   <= dig_s1;
            dig_prev <= dig_s2;
            seg_s1   <= bus.seg[7:SEG_LO];
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
        end
    end

    always_comb begin
        zeros = '0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            if (!dig_s2[i]) begin
                zeros = zeros + 3'd1;
                idx   = 2'(i);
            end
        end
    end

    assign one_hot    = (zeros == 3'd1);
    assign multi      = (zeros > 3'd1);
    assign changed    = (dig_s2 != dig_prev) || (seg_s2 != seg_prev);
    assign in_mask    = DIG_MASK[idx];
    assign dec        = decode7(seg_s2[7:1]);
    assign frame_done = ((captured & DIG_MASK) == DIG_MASK);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (one_hot) state_nxt = SETTLE;
            SETTLE: begin
                if (changed) begin
                    if (!one_hot) state_nxt = IDLE;
                end else if (cnt == 8'(STABLE_CNT - 1)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD:   if (changed) state_nxt = one_hot ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_restart = 1'b0;
        cnt_inc     = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE:   cnt_restart = one_hot;
            SETTLE: begin
                cnt_restart = changed && one_hot;
                cnt_inc     = !changed;
                accept      = !changed && (cnt == 8'(STABLE_CNT - 1));
            end
            HOLD:   cnt_restart = changed && one_hot;
            default: ;
        endcase
        wr        = accept && in_mask && dec[4];
        err_event = (changed && multi) || (accept && in_mask && !dec[4]);
    end

    // A write coinciding with frame completion lands after the clear, so it starts the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            captured      <= '0;
            shadow        <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            if (cnt_restart)            cnt <= 8'd1;
            else if (cnt_inc)           cnt <= cnt + 8'd1;
            else if (state_nxt == IDLE) cnt <= '0;

            if (wr) shadow[idx*4 +: 4] <= dec[3:0];
            if (frame_done) data_q <= shadow;
            captured <= (frame_done ? 4'b0000 : captured) | (wr ? ~dig_s2 : 4'b0000);

            frame_valid_q <= frame_done;
            err_q         <= err_event;
            if (err_event && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

`ifdef SEG_CAPTURE_DP_EN
    logic [3:0] shadow_dp, dp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dp <= '0;
            dp_q      <= '0;
        end else begin
            if (wr)         shadow_dp[idx] <= ~seg_s2[0];
            if (frame_done) dp_q <= shadow_dp;
        end
    end

    assign bus.dp_out = dp_q;
`else
    assign bus.dp_out = 4'b0000;
`endif

    assign bus.data_out    = data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - scoreboard bench for seg_capture
module tb_seg_capture;
    localparam int unsigned STABLE = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycles = 0;
    int   frame_cyc = 0;
    int   err_seen = 0;
    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];
    logic [19:0] e, g;

`ifdef SEG_CAPTURE_DP_EN
    localparam logic [3:0] DP_EXP = 4'b0001;
`else
    localparam logic [3:0] DP_EXP = 4'b0000;
`endif

    seg_capture_if bus();

    seg_capture #(.STABLE_CNT(STABLE), .DIG_MASK(4'b0011)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.frame_valid) begin
                got_q.push_back({bus.dp_out, bus.data_out});
                frame_cyc = cycles;
            end
            if (bus.err) err_seen++;
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
        bus.dig = d;
        bus.seg = s;
        tick(n);
    endtask

    task automatic do_reset();
        bus.dig = 4'hF;
        bus.seg = 8'hFF;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        exp_q.delete();
        got_q.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus.data_out); end
        checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", bus.frame_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", bus.err_cnt); end
        checks++; if (bus.dp_out !== 4'b0000) begin errors++; $display("FAIL reset_dp got %b want 0000", bus.dp_out); end
    endtask

    task automatic test_frame();
        int c0;
        do_reset();
        drive(4'b1110, 8'h0D, 40);
        exp_q.push_back({4'b0000, 16'h0013});
        c0 = cycles;
        drive(4'b1101, 8'h9F, 40);
        drive(4'b1111, 8'hFF, 5);
        checks++; if (frame_cyc - c0 != int'(STABLE) + 3) begin errors++; $display("FAIL frame_latency got %0d want %0d", frame_cyc - c0, STABLE + 3); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g[15:0] !== e[15:0]) begin errors++; $display("FAIL frame_data got %h want %h", g[15:0], e[15:0]); end
        end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL frame_errcnt got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_threshold();
        do_reset();
        drive(4'b1110, 8'h0D, STABLE - 1);
        drive(4'b1101, 8'h9F, 40);
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL short_hold_frames got %0d want 0", got_q.size()); end
        drive(4'b1110, 8'h0D, STABLE);
        exp_q.push_back({4'b0000, 16'h0013});
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL exact_hold_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g[15:0] !== e[15:0]) begin errors++; $display("FAIL exact_hold_data got %h want %h", g[15:0], e[15:0]); end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 16; i++) drive(4'b1110, (i % 2 == 0) ? 8'h03 : 8'h9F, 5);
        drive(4'b1101, 8'h9F, 40);
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_frames got %0d want 0", got_q.size()); end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL glitch_err got %0d want 0", err_seen); end
    endtask

    task automatic test_bad_pattern();
        do_reset();
        drive(4'b1110, 8'hFF, 40);
        checks++; if (err_seen != 1) begin errors++; $display("FAIL badpat_pulses got %0d want 1", err_seen); end
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL badpat_errcnt got %0d want 1", bus.err_cnt); end
        drive(4'b1101, 8'h9F, 40);
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL badpat_frames got %0d want 0", got_q.size()); end
    endtask

    task automatic test_multi_dig();
        do_reset();
        drive(4'b1100, 8'h0D, 20);
        checks++; if (err_seen != 1) begin errors++; $display("FAIL multidig_pulses got %0d want 1", err_seen); end
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL multidig_errcnt got %0d want 1", bus.err_cnt); end
        drive(4'b1111, 8'h0D, 100);
        checks++; if (err_seen != 1) begin errors++; $display("FAIL blank_err got %0d want 1", err_seen); end
    endtask

    task automatic test_mask();
        do_reset();
        drive(4'b1011, 8'hFF, 40);
        drive(4'b0111, 8'h0D, 40);
        drive(4'b1111, 8'hFF, 10);
        checks++; if (err_seen != 0) begin errors++; $display("FAIL mask_err got %0d want 0", err_seen); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mask_frames got %0d want 0", got_q.size()); end
    endtask

    task automatic test_err_sat();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(4'b1100, 8'hFF, 4);
            drive(4'b1111, 8'hFF, 4);
        end
        checks++; if (err_seen != 260) begin errors++; $display("FAIL sat_pulses got %0d want 260", err_seen); end
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_errcnt got %0d want 255", bus.err_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        drive(4'b1110, 8'h0D, 40);
        drive(4'b1111, 8'hFF, 3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        drive(4'b1101, 8'h9F, 40);
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_frames got %0d want 0", got_q.size()); end
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL midrst_data got %h want 0000", bus.data_out); end
        drive(4'b1110, 8'h49, 40);
        exp_q.push_back({4'b0000, 16'h0015});
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g[15:0] !== e[15:0]) begin errors++; $display("FAIL midrst_data2 got %h want %h", g[15:0], e[15:0]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(4'b1110, 8'h0D, 40);
        drive(4'b1110, 8'h49, 40);
        drive(4'b1101, 8'h9F, 40);
        exp_q.push_back({4'b0000, 16'h0015});
        drive(4'b1110, 8'h41, 40);
        drive(4'b1101, 8'h03, 40);
        exp_q.push_back({4'b0000, 16'h0006});
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g[15:0] !== e[15:0]) begin errors++; $display("FAIL b2b_data got %h want %h", g[15:0], e[15:0]); end
        end
    endtask

    task automatic test_dp();
        do_reset();
        drive(4'b1110, 8'h0C, 40);
        drive(4'b1101, 8'h9F, 40);
        exp_q.push_back({DP_EXP, 16'h0013});
        drive(4'b1111, 8'hFF, 10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL dp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL dp_frame got dp=%b data=%h want dp=%b data=%h", g[19:16], g[15:0], e[19:16], e[15:0]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.dig = 4'hF;
        bus.seg = 8'hFF;
        test_reset();
        test_frame();
        test_threshold();
        test_glitch();
        test_bad_pattern();
        test_multi_dig();
        test_mask();
        test_err_sat();
        test_reset_mid_frame();
        test_back_to_back();
        test_dp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 16, the number of consecutive identical synchronized samples needed to accept a digit pattern (legal range 2..255).
REQ-002 SHALL have parameter DIG_MASK, default 4'b0011, marking the digit positions that make up a frame.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-005 SHALL have port dig, input, 4 bits, multiplexed digit select, active low, asynchronous to clk.
REQ-006 SHALL have port seg, input, 8 bits, segment lines a..dp from MSB to LSB, active low, asynchronous to clk.
REQ-007 SHALL have port data_out, output, 16 bits, the last complete frame as BCD: digit n occupies bits [4n+3:4n].
REQ-008 SHALL have port frame_valid, output, 1 bit, a one-cycle pulse marking a data_out update.
REQ-009 SHALL have port err, output, 1 bit, a one-cycle pulse on each protocol error.
REQ-010 SHALL have port err_cnt, output, 8 bits, a saturating count of errors.
REQ-011 SHALL have port dp_out, output, 4 bits, per-digit decimal point, active high (see Configuration).

Function
REQ-012 SHALL pass dig and seg through a 2-flop synchronizer; all decisions use the synchronized values.
REQ-013 SHALL decode seg[7:1], with dp masked, as follows: 0x01->0, 0x4F->1, 0x12->2, 0x06->3, 0x4C->4, 0x24->5, 0x20->6, 0x0F->7, 0x00->8, 0x04->9; any other value is an undefined pattern.
REQ-014 SHALL implement the FSM IDLE/SETTLE/HOLD: in IDLE, dig all-ones or with more than one zero bit; in SETTLE, exactly one zero bit in dig, counting stable samples; in HOLD, a pattern has been accepted.
REQ-015 SHALL make these transitions: IDLE->SETTLE on a one-hot-low dig, clearing the counter to 1; in SETTLE, any change in {dig,seg} restarts the counter at 1.
REQ-016 SHALL, on reaching STABLE_CNT in SETTLE, go to HOLD; in the same cycle it writes the decoded BCD into shadow digit n and sets captured[n], where n is the index of the zero bit in dig.
REQ-017 SHALL, in HOLD, return to SETTLE (counter=1) on any change in {dig,seg} to another one-hot-low dig, and to IDLE on any change to an invalid dig.
REQ-018 SHALL, if the pattern is undefined at acceptance, pulse err, increment err_cnt, write nothing, and go to HOLD.
REQ-019 SHALL treat a dig with two or more zero bits in the sample after a change as an error (err pulse, err_cnt+1) and go to IDLE; all-ones dig is blanking and is not an error.
REQ-020 SHALL ignore digit positions outside DIG_MASK: no write, no error.
REQ-021 SHALL complete a frame when (captured & DIG_MASK) == DIG_MASK; in the next cycle it copies the shadow registers to data_out, pulses frame_valid for one cycle, and clears captured.
REQ-022 SHALL let a repeat capture of the same digit before frame completion overwrite its shadow value (the latest value wins).
REQ-023 SHALL, if frame completion and a new acceptance coincide, let the new acceptance land in the shadow and set captured after the clear; it is not lost.
REQ-024 SHALL hold err_cnt at 255 once it reaches 255.
REQ-025 SHALL give a latency of 2 (synchronizer) + STABLE_CNT-1 + 1 cycles from the input change to the shadow write, plus 1 cycle to frame_valid.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, set state=IDLE, counter=0, captured=0, shadow=0, data_out=16'h0000, dp_out=4'b0000, frame_valid=0, err=0, err_cnt=0, and synchronizers to all-ones.
REQ-027 SHALL, on reset mid-SETTLE or mid-frame, discard partial captures; no frame_valid is issued for them.

Configuration
REQ-028 SHALL support macro SEG_CAPTURE_DP_EN: when defined, seg[0] is captured alongside the digit (dp_out[n] = ~seg[0]) and is copied to dp_out at frame completion.
REQ-029 SHALL, without SEG_CAPTURE_DP_EN, hold dp_out at 4'b0000; seg[0] is still ignored for decoding and stability only counts seg[7:1].

Verification
REQ-030 SHALL verify: dig=1110, seg=0x0D for 40 cycles, then dig=1101, seg=0x9F for 40 cycles -> frame_valid pulse, data_out=16'h0013, err_cnt=0.
REQ-031 SHALL verify glitch rejection: dig=1110, seg toggles 0x03/0x9F every 5 cycles with STABLE_CNT=16 -> no capture, no frame_valid.
REQ-032 SHALL verify: seg=0xFF on dig=1110 held 40 cycles -> one err pulse, err_cnt=1, no shadow write.
REQ-033 SHALL verify: dig=1100 -> err pulse, state=IDLE; dig=1111 blanking for 100 cycles -> no err.
REQ-034 SHALL verify: rst asserted after digit 0 is captured but before digit 1 -> data_out=0 and no frame_valid until both digits are recaptured.
REQ-035 SHALL verify, with SEG_CAPTURE_DP_EN: seg=0x0C on dig=1110 and seg=0x9F on dig=1101 -> data_out=16'h0013, dp_out=4'b0001.
